// File: rtl/skintone_pkg.sv
// Shared constants and widths for the YCbCr skin-tone scorer.
// The default ellipse model is centred at (Cb, Cr) = (110, 155) and rotated by theta = 2.53 rad.
package skintone_pkg;

  localparam int CHROMA_W = 10;  // signed width of centred chroma and of rotated coordinates
  localparam int DIST_W   = 25;  // unsigned width of the weighted squared distance

  localparam int CB_CENTER = 110;
  localparam int CR_CENTER = 155;
  localparam int Y_MIN     = 40;
  localparam int Y_MAX     = 235;
  localparam int COS_Q8    = -210;
  localparam int SIN_Q8    = 147;
  localparam int KX        = 102;
  localparam int KY        = 333;

endpackage

// File: rtl/skintone_rotate.sv
// Rotates centred chroma into the ellipse frame. Inputs are Q0 and coefficients are Q8.
// Each result is floored back to Q0 by an arithmetic shift.
module skintone_rotate
  import skintone_pkg::*;
#(
  parameter int P_COS_Q8 = COS_Q8,
  parameter int P_SIN_Q8 = SIN_Q8
) (
  input  logic signed [CHROMA_W-1:0] i_tcb,
  input  logic signed [CHROMA_W-1:0] i_tcr,
  output logic signed [CHROMA_W-1:0] o_xx,
  output logic signed [CHROMA_W-1:0] o_yy
);

  localparam int PW = 2 * CHROMA_W;
  localparam logic signed [PW-1:0] L_COS  = PW'(P_COS_Q8);
  localparam logic signed [PW-1:0] L_SIN  = PW'(P_SIN_Q8);
  localparam logic signed [PW-1:0] L_NSIN = PW'(-P_SIN_Q8);

  logic signed [PW-1:0] w_tcb;
  logic signed [PW-1:0] w_tcr;
  logic signed [PW-1:0] w_xsum;
  logic signed [PW-1:0] w_ysum;

  assign w_tcb  = {{CHROMA_W{i_tcb[CHROMA_W-1]}}, i_tcb};
  assign w_tcr  = {{CHROMA_W{i_tcr[CHROMA_W-1]}}, i_tcr};
  assign w_xsum = L_COS * w_tcb + L_SIN * w_tcr;
  assign w_ysum = L_NSIN * w_tcb + L_COS * w_tcr;

  // The rotated magnitude never exceeds about 210, so the truncation back to CHROMA_W bits is lossless.
  assign o_xx = CHROMA_W'(w_xsum >>> 8);
  assign o_yy = CHROMA_W'(w_ysum >>> 8);

endmodule

// File: rtl/skintone_detector.sv
// Four-stage per-pixel skin-likelihood scorer: centre, rotate, weighted distance, score.
// The output score is 255 at the ellipse centre and 0 outside the model or the luma window.
module skintone_detector
  import skintone_pkg::*;
#(
  parameter int P_CB_CENTER = CB_CENTER,
  parameter int P_CR_CENTER = CR_CENTER,
  parameter int P_Y_MIN     = Y_MIN,
  parameter int P_Y_MAX     = Y_MAX,
  parameter int P_COS_Q8    = COS_Q8,
  parameter int P_SIN_Q8    = SIN_Q8,
  parameter int P_KX        = KX,
  parameter int P_KY        = KY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [7:0] Y,
  input  logic [7:0] Cb,
  input  logic [7:0] Cr,
  output logic       valid_out,
  output logic [7:0] skinScore
);

  logic signed [CHROMA_W-1:0] w_tcb, w_tcr, w_xx, w_yy;
  logic                       w_luma_ok;
  logic [CHROMA_W-1:0]        w_xabs, w_yabs;
  logic [DIST_W-1:0]          w_pre;

  logic                       r_v1, r_v2, r_v3;
  logic                       r_luma1, r_luma2, r_luma3;
  logic signed [CHROMA_W-1:0] r_tcb, r_tcr, r_xx, r_yy;
  logic [DIST_W-1:0]          r_pre;

  // S1: centre the chroma and apply the luma window.
  assign w_tcb     = $signed({2'b00, Cb}) - $signed(CHROMA_W'(P_CB_CENTER));
  assign w_tcr     = $signed({2'b00, Cr}) - $signed(CHROMA_W'(P_CR_CENTER));
  assign w_luma_ok = (Y >= 8'(P_Y_MIN)) && (Y <= 8'(P_Y_MAX));

  skintone_rotate #(
    .P_COS_Q8(P_COS_Q8),
    .P_SIN_Q8(P_SIN_Q8)
  ) u_rotate (
    .i_tcb(r_tcb),
    .i_tcr(r_tcr),
    .o_xx (w_xx),
    .o_yy (w_yy)
  );

  // S3: squares use magnitudes, so the weighted sum stays unsigned and fits in DIST_W bits.
  assign w_xabs = r_xx[CHROMA_W-1] ? CHROMA_W'(-r_xx) : CHROMA_W'(r_xx);
  assign w_yabs = r_yy[CHROMA_W-1] ? CHROMA_W'(-r_yy) : CHROMA_W'(r_yy);
  assign w_pre  = DIST_W'(w_xabs) * DIST_W'(w_xabs) * DIST_W'(P_KX)
                + DIST_W'(w_yabs) * DIST_W'(w_yabs) * DIST_W'(P_KY);

  // NOTE: data registers carry no reset; only the valid bits and the output are cleared,
  // so a stale data value can never be observed as a result.
  always_ff @(posedge clk) begin
    r_tcb   <= w_tcb;
    r_tcr   <= w_tcr;
    r_luma1 <= w_luma_ok;
    r_xx    <= w_xx;
    r_yy    <= w_yy;
    r_luma2 <= r_luma1;
    r_pre   <= w_pre;
    r_luma3 <= r_luma2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
      valid_out <= 1'b0;
      skinScore <= 8'd0;
    end else begin
      r_v1      <= valid_in;
      r_v2      <= r_v1;
      r_v3      <= r_v2;
      valid_out <= r_v3;
      if (r_v3) begin
        // S4: any distance at or beyond 65536 lies outside the ellipse.
        if (!r_luma3 || (|r_pre[DIST_W-1:16]))
          skinScore <= 8'd0;
        else
          skinScore <= 8'd255 - r_pre[15:8];
      end
    end
  end

endmodule

// File: tb/tb_skintone_detector.sv
// Bench for skintone_detector. It combines a directed vector table, hand-written stream
// and reset sequences, and random pixels, all checked every cycle against an arithmetic model.
module tb_skintone_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [7:0] Y, Cb, Cr;
  logic       valid_out;
  logic [7:0] skinScore;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int HIST = 4096;
  logic hist_v [HIST];
  int   hist_y [HIST];
  int   hist_cb[HIST];
  int   hist_cr[HIST];
  int   cyc = 0;
  int   last_rst = -1;
  int   model_score = 0;

  skintone_detector dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .Y        (Y),
    .Cb       (Cb),
    .Cr       (Cr),
    .valid_out(valid_out),
    .skinScore(skinScore)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Reference score computed directly from the ellipse equation using integer arithmetic.
  function automatic int ref_score(input int y, input int cb, input int cr);
    int tcb, tcr, xx, yy, d;
    tcb = cb - 110;
    tcr = cr - 155;
    xx  = (-210 * tcb + 147 * tcr) >>> 8;
    yy  = (-147 * tcb - 210 * tcr) >>> 8;
    d   = xx * xx * 102 + yy * yy * 333;
    if (y < 40 || y > 235 || d >= 65536) return 0;
    return 255 - d / 256;
  endfunction

  // Apply one cycle of input, then check both outputs against the model just after the edge.
  task automatic step(input logic v, input int y, input int cb, input int cr, input logic r);
    int idx;
    int ev;
    @(negedge clk);
    rst      = r;
    valid_in = v;
    Y        = 8'(y);
    Cb       = 8'(cb);
    Cr       = 8'(cr);
    hist_v[cyc]  = v;
    hist_y[cyc]  = y;
    hist_cb[cyc] = cb;
    hist_cr[cyc] = cr;
    if (r) last_rst = cyc;
    @(posedge clk);
    #1;
    idx = cyc - 3;
    ev  = 0;
    if (r) begin
      model_score = 0;
    end else if (idx > last_rst && idx >= 0 && hist_v[idx]) begin
      ev = 1;
      model_score = ref_score(hist_y[idx], hist_cb[idx], hist_cr[idx]);
    end
    check("valid_out", int'(valid_out), ev);
    check("skinScore", int'(skinScore), model_score);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0);
  endtask

  typedef struct {
    int y;
    int cb;
    int cr;
    int exp_score;
  } vec_t;

  vec_t vecs[10];
  int   run_len;
  int   max_run;

  initial begin
    rst = 1'b1; valid_in = 1'b0; Y = '0; Cb = '0; Cr = '0;

    // Reset state
    step(1'b0, 0, 0, 0, 1'b1);
    step(1'b0, 0, 0, 0, 1'b1);
    check("reset_valid", int'(valid_out), 0);
    check("reset_score", int'(skinScore), 0);
    idle(2);

    // Directed table: one pixel, then a gap, then check the held score
    vecs[0] = '{85, 110, 155, 255};
    vecs[1] = '{85, 111, 155, 254};
    vecs[2] = '{85, 250, 0, 0};
    vecs[3] = '{250, 250, 0, 0};
    vecs[4] = '{250, 0, 0, 0};
    vecs[5] = '{250, 250, 250, 0};
    vecs[6] = '{250, 110, 155, 0};
    vecs[7] = '{40, 110, 155, 255};
    vecs[8] = '{235, 110, 155, 255};
    vecs[9] = '{39, 110, 155, 0};
    for (int i = 0; i < 10; i++) begin
      step(1'b1, vecs[i].y, vecs[i].cb, vecs[i].cr, 1'b0);
      idle(5);
      check($sformatf("vec%0d_held", i), int'(skinScore), vecs[i].exp_score);
    end

    // Stream of six back-to-back pixels: valid_out must form one contiguous six-cycle run
    run_len = 0;
    max_run = 0;
    step(1'b1, 250, 250, 0, 1'b0);
    step(1'b1, 250, 0, 0, 1'b0);
    step(1'b1, 250, 250, 0, 1'b0);
    step(1'b1, 250, 250, 250, 1'b0);
    if (valid_out) run_len++;
    step(1'b1, 85, 110, 155, 1'b0);
    if (valid_out) run_len++;
    step(1'b1, 250, 0, 0, 1'b0);
    if (valid_out) run_len++;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 0, 0, 0, 1'b0);
      if (valid_out) run_len++;
      else if (run_len > 0) begin
        if (run_len > max_run) max_run = run_len;
        run_len = 0;
      end
      if (i == 1) check("stream_5th_score", int'(skinScore), 255);
    end
    check("stream_run_len", max_run, 6);

    // Reset with three pixels in flight after a held score of 255
    step(1'b1, 85, 110, 155, 1'b0);
    idle(4);
    check("pre_reset_hold", int'(skinScore), 255);
    step(1'b1, 85, 110, 155, 1'b0);
    step(1'b1, 85, 111, 155, 1'b0);
    step(1'b1, 40, 110, 155, 1'b0);
    step(1'b0, 0, 0, 0, 1'b1);
    check("midreset_valid", int'(valid_out), 0);
    check("midreset_score", int'(skinScore), 0);
    idle(6);

    // Random pixels, biased toward the ellipse so that non-zero scores are exercised
    for (int i = 0; i < 600; i++) begin
      int cb, cr, y;
      if ($urandom_range(0, 1) == 1) begin
        cb = 110 + int'($urandom_range(0, 40)) - 20;
        cr = 155 + int'($urandom_range(0, 40)) - 20;
      end else begin
        cb = int'($urandom_range(0, 255));
        cr = int'($urandom_range(0, 255));
      end
      y = int'($urandom_range(0, 255));
      step(($urandom_range(0, 3) != 0), y, cb, cr, ($urandom_range(0, 99) == 0));
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/skintone_detector.md
Name: skintone_detector

Overview:
- Per-pixel skin-likelihood scorer for a YCbCr video stream.
- Accepts one pixel per clock, qualified by valid_in.
- Scores the chroma against a rotated elliptical skin model, gated by a luma window.
- Emits an 8-bit skinScore (255 = ellipse centre, 0 = outside the model) a fixed 4 cycles later. No backpressure.

Parameters:
- CB_CENTER, 110: Cb value of the ellipse centre.
- CR_CENTER, 155: Cr value of the ellipse centre.
- Y_MIN, 40: lowest luma accepted as skin.
- Y_MAX, 235: highest luma accepted as skin.
- COS_Q8, -210: cos(theta) in signed Q8, theta = 2.53 rad.
- SIN_Q8, 147: sin(theta) in signed Q8.
- KX, 102: 65536 / a^2 (a = 25.39), x-axis weight.
- KY, 333: 65536 / b^2 (b = 14.03), y-axis weight.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- valid_in  in  1  input pixel qualifier.
- Y  in  8  luma, unsigned.
- Cb  in  8  blue chroma, unsigned.
- Cr  in  8  red chroma, unsigned.
- valid_out  out  1  skinScore holds a new result this cycle.
- skinScore  out  8  skin score, unsigned 0..255.

Behaviour:
- Reset (rst high at a clk edge, synchronous, active-high): all valid pipeline bits clear, valid_out = 0, skinScore = 0. Pixels in flight are discarded. First valid_out can assert 4 cycles after the first post-reset valid_in.
- Pipeline is 4 register stages, one pixel per cycle. Data registers advance every cycle; the valid bit travels alongside.
- S1:
  - TCb = Cb - CB_CENTER and TCr = Cr - CR_CENTER, signed 10-bit.
  - luma_ok = (Y_MIN <= Y <= Y_MAX).
- S2 (rotation):
  - xx = (COS_Q8*TCb + SIN_Q8*TCr) >>> 8.
  - yy = (-SIN_Q8*TCb + COS_Q8*TCr) >>> 8.
  - Arithmetic shift (floor), signed 10-bit results.
- S3: pre_skintone = xx^2*KX + yy^2*KY, unsigned 25-bit, no overflow possible.
- S4 (score):
  - If luma_ok = 0 or pre_skintone >= 65536: skintone = 0.
  - Else: skintone = 255 - pre_skintone[15:8].
- skinScore loads only when the S4 valid bit is set; otherwise it holds its last value.
- valid_out equals that S4 valid bit (latency exactly 4 clocks from the edge sampling valid_in).
- Boundaries:
  - pre_skintone = 65535 -> 0.
  - pre_skintone < 256 -> 255.
  - Y = Y_MIN or Y = Y_MAX counts as inside the window.
  - Back-to-back valid pixels produce back-to-back outputs.
  - Gaps in valid_in reproduce as identical gaps in valid_out.

Decomposition:
- Package skintone_pkg holds the default constants above and the widths (CHROMA_W = 10, DIST_W = 25).
- One natural sub-module: skintone_rotate, the S2 signed multiply/shift for xx/yy, instantiated once.
- The remaining stages stay inline.

Test Plan:
- Centre pixel: Y=85, Cr=155, Cb=110 valid, then a gap.
  -> 4 cycles later valid_out=1, skinScore=255; next cycle valid_out=0, skinScore holds 255.
- Near-centre: Y=85, Cr=155, Cb=111.
  -> xx=-1, yy=-1, pre_skintone=435, skinScore=254.
- Far chroma, valid luma: Y=85, Cr=0, Cb=250.
  -> xx=-204, pre_skintone >= 65536, skinScore=0.
- Luma gate: Y=250 with Cr/Cb of (0,250), (0,0), (250,250), (155,110).
  -> all skinScore=0. Also Y=40 with Cr=155, Cb=110 -> 255.
- Stream of 6 back-to-back valid pixels, each a row of (Y, Cr, Cb):
  - Rows: (250,0,250), (250,0,0), (250,0,250), (250,250,250), (85,155,110), (250,0,0).
  - -> valid_out high for exactly 6 consecutive cycles starting 4 cycles after the first input.
  - -> scores 0, 0, 0, 0, 255, 0.
- Reset mid-stream: assert rst for 1 cycle while 3 pixels are in flight.
  -> valid_out=0 and skinScore=0 the next cycle; the in-flight pixels never appear.
